regfile_scoreboard: RTL and testbench

- Architectural integer register file for the core, with one write port and two read ports.
- Exposes all registers as one flattened bus. This bus is the indata of the generic mux used for operand selection.
- Writeback data arrives through the generic demux/write path.
- Carries a per-register busy scoreboard, so the issue stage stalls on RAW/WAW hazards until writeback.

---
 rtl/regfile_scoreboard_pkg.sv | 16 +
 rtl/regfile_scoreboard_mux.sv | 20 ++
 rtl/regfile_scoreboard.sv | 110 +++++++++++
 tb/tb_regfile_scoreboard.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_scoreboard_pkg.sv
// Shared constants for the integer register file and its issue scoreboard.
// Latency: n/a (constants only).
// Backpressure: n/a.
//
// Holds the default register width and address width, the register count
// derived from them, and the hard-wired zero register address.
package regfile_scoreboard_pkg;

  localparam int XLEN_DEFAULT   = 32;
  localparam int AWIDTH_DEFAULT = 5;
  localparam int NREGS_DEFAULT  = 1 << AWIDTH_DEFAULT;

  // Address of the hard-wired zero register: never written, never reserved.
  localparam int REG_ZERO = 0;

endpackage : regfile_scoreboard_pkg

// File: rtl/regfile_scoreboard_mux.sv
// Generic N-way bus multiplexer: selects one BUSWIDTH slice of a flattened bus.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   indata  - 2**SELWIDTH slices, slice i at [BUSWIDTH*i +: BUSWIDTH]
//   sel     - slice index
//   outdata - selected slice
module regfile_scoreboard_mux #(
  parameter int BUSWIDTH = 32,
  parameter int SELWIDTH = 5
) (
  input  logic [BUSWIDTH*(2**SELWIDTH)-1:0] indata,
  input  logic [SELWIDTH-1:0]               sel,
  output logic [BUSWIDTH-1:0]               outdata
);

  assign outdata = indata[sel*BUSWIDTH +: BUSWIDTH];

endmodule : regfile_scoreboard_mux

// File: rtl/regfile_scoreboard.sv
// Integer register file (1 write, 2 read ports) with a per-register busy scoreboard.
// Latency: reads combinational with write-first bypass; regs/busy/count update 1 cycle after the edge.
// Backpressure: issue_ready drops while a source or destination register is reserved and not being written back.
//
// Ports:
//   clk, rst                    - core clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data       - writeback port (also releases the reservation)
//   rs1_addr/rs1_data, rs2_*    - combinational read ports
//   regs_flat                   - all registers, register i at [XLEN*i +: XLEN]
//   issue_valid/issue_rd        - issue stage request and its destination (0 = none)
//   issue_ready                 - no hazard on rs1/rs2/rd this cycle
//   busy_flat, pending_cnt      - reservation bits and their registered popcount
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int AWIDTH = AWIDTH_DEFAULT,
  localparam int NREGS = 1 << AWIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [AWIDTH-1:0]       wr_addr,
  input  logic [XLEN-1:0]         wr_data,
  input  logic [AWIDTH-1:0]       rs1_addr,
  input  logic [AWIDTH-1:0]       rs2_addr,
  output logic [XLEN-1:0]         rs1_data,
  output logic [XLEN-1:0]         rs2_data,
  output logic [XLEN*NREGS-1:0]   regs_flat,
  input  logic                    issue_valid,
  input  logic [AWIDTH-1:0]       issue_rd,
  output logic                    issue_ready,
  output logic [NREGS-1:0]        busy_flat,
  output logic [AWIDTH:0]         pending_cnt
);

  localparam logic [AWIDTH-1:0] ZERO_ADDR = AWIDTH'(REG_ZERO);
  localparam logic [NREGS-1:0]  ONE_BIT   = NREGS'(1);

  logic              wr_live;
  logic [NREGS-1:0]  wr_mask;
  logic [NREGS-1:0]  busy_eff;
  logic              issue_fire;
  logic [NREGS-1:0]  set_mask;
  logic [NREGS-1:0]  busy_next;
  logic [AWIDTH:0]   cnt_next;
  logic [XLEN-1:0]   rs1_mux;
  logic [XLEN-1:0]   rs2_mux;

  // Writes to the zero register are dropped everywhere: data, bypass, and release.
  assign wr_live = wr_en && (wr_addr != ZERO_ADDR);
  assign wr_mask = wr_live ? (ONE_BIT << wr_addr) : '0;

  // A writeback landing this cycle already satisfies any waiter on that register.
  assign busy_eff = busy_flat & ~wr_mask;

  // Ready is a pure hazard check; it does not look at issue_valid.
  assign issue_ready = ~(busy_eff[rs1_addr] | busy_eff[rs2_addr] | busy_eff[issue_rd]);

  assign issue_fire = issue_valid && issue_ready && (issue_rd != ZERO_ADDR);
  assign set_mask   = issue_fire ? (ONE_BIT << issue_rd) : '0;

  // Clear first, then set: a same-cycle reservation of the written register survives.
  assign busy_next = (busy_flat & ~wr_mask) | set_mask;

  always_comb begin
    cnt_next = '0;
    for (int i = 0; i < NREGS; i++) begin
      cnt_next = cnt_next + {{AWIDTH{1'b0}}, busy_next[i]};
    end
  end

  // Register 0 is never written, so its slice of regs_flat stays at its reset value of 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_flat   <= '0;
      busy_flat   <= '0;
      pending_cnt <= '0;
    end else begin
      if (wr_live) begin
        regs_flat[wr_addr*XLEN +: XLEN] <= wr_data;
      end
      busy_flat   <= busy_next;
      pending_cnt <= cnt_next;
    end
  end

  regfile_scoreboard_mux #(
    .BUSWIDTH (XLEN),
    .SELWIDTH (AWIDTH)
  ) u_rs1_mux (
    .indata  (regs_flat),
    .sel     (rs1_addr),
    .outdata (rs1_mux)
  );

  regfile_scoreboard_mux #(
    .BUSWIDTH (XLEN),
    .SELWIDTH (AWIDTH)
  ) u_rs2_mux (
    .indata  (regs_flat),
    .sel     (rs2_addr),
    .outdata (rs2_mux)
  );

  // Write-first bypass sits after the mux so the flattened bus stays purely registered.
  assign rs1_data = (wr_live && (wr_addr == rs1_addr)) ? wr_data : rs1_mux;
  assign rs2_data = (wr_live && (wr_addr == rs2_addr)) ? wr_data : rs2_mux;

endmodule : regfile_scoreboard

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed stimulus pushes expectations tagged with
// the cycle they apply to; a negedge monitor compares every expectation due that cycle.
module tb_regfile_scoreboard;

  localparam int XLEN   = 32;
  localparam int AWIDTH = 5;
  localparam int NREGS  = 32;

  localparam int K_RS1  = 0;
  localparam int K_RS2  = 1;
  localparam int K_REG  = 2;
  localparam int K_BUSY = 3;
  localparam int K_CNT  = 4;
  localparam int K_RDY  = 5;

  logic                  clk;
  logic                  rst;
  logic                  wr_en;
  logic [AWIDTH-1:0]     wr_addr;
  logic [XLEN-1:0]       wr_data;
  logic [AWIDTH-1:0]     rs1_addr;
  logic [AWIDTH-1:0]     rs2_addr;
  logic [XLEN-1:0]       rs1_data;
  logic [XLEN-1:0]       rs2_data;
  logic [XLEN*NREGS-1:0] regs_flat;
  logic                  issue_valid;
  logic [AWIDTH-1:0]     issue_rd;
  logic                  issue_ready;
  logic [NREGS-1:0]      busy_flat;
  logic [AWIDTH:0]       pending_cnt;

  regfile_scoreboard #(
    .XLEN   (XLEN),
    .AWIDTH (AWIDTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .regs_flat   (regs_flat),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .busy_flat   (busy_flat),
    .pending_cnt (pending_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    int          kind;
    int          idx;
    logic [31:0] exp;
  } chk_t;

  chk_t  q[$];
  string nq[$];
  int    errors = 0;
  int    checks = 0;
  bit    done   = 1'b0;

  function automatic logic [31:0] sample(input int kind, input int idx);
    logic [31:0] v;
    case (kind)
      K_RS1:   v = rs1_data;
      K_RS2:   v = rs2_data;
      K_REG:   v = regs_flat[idx*XLEN +: XLEN];
      K_BUSY:  v = busy_flat;
      K_CNT:   v = {26'd0, pending_cnt};
      default: v = {31'd0, issue_ready};
    endcase
    return v;
  endfunction

  // Monitor: every expectation due this cycle is compared on the falling edge.
  always @(negedge clk) begin
    if (!done) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].cyc == cyc) begin
          logic [31:0] act;
          act = sample(q[i].kind, q[i].idx);
          checks++;
          if (act !== q[i].exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)",
                     nq[i], act, q[i].exp, cyc);
          end
          q.delete(i);
          nq.delete(i);
        end
      end
    end
  end

  // Queue an expectation for the current cycle (dly=0) or after the next edge (dly=1).
  task automatic expect_val(input string name, input int kind, input int idx,
                            input logic [31:0] exp, input int dly);
    chk_t c;
    c.cyc  = cyc + dly;
    c.kind = kind;
    c.idx  = idx;
    c.exp  = exp;
    q.push_back(c);
    nq.push_back(name);
  endtask

  // Advance to just after the next rising edge, where inputs are changed.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en       = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    issue_valid = 1'b0;
    issue_rd    = '0;
    rs1_addr    = '0;
    rs2_addr    = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    rst = 1'b0;

    // Post-reset: every register reads 0, scoreboard empty, ready.
    for (int i = 0; i < NREGS; i++) begin
      rs1_addr = AWIDTH'(i);
      rs2_addr = AWIDTH'(NREGS - 1 - i);
      expect_val("reset_rs1", K_RS1, 0, 32'h0, 0);
      expect_val("reset_rs2", K_RS2, 0, 32'h0, 0);
      expect_val("reset_reg", K_REG, i, 32'h0, 0);
      if (i % 8 == 0) begin
        expect_val("reset_busy",  K_BUSY, 0, 32'h0, 0);
        expect_val("reset_cnt",   K_CNT,  0, 32'h0, 0);
        expect_val("reset_ready", K_RDY,  0, 32'h1, 0);
      end
      step();
    end

    // Write x5 with same-cycle read: bypass now, registered value next cycle.
    idle_inputs();
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; rs1_addr = 5'd5;
    expect_val("bypass_rs1_x5", K_RS1, 0, 32'hDEADBEEF, 0);
    expect_val("rs2_x0_zero",   K_RS2, 0, 32'h0,        0);
    expect_val("regs_flat_x5",  K_REG, 5, 32'hDEADBEEF, 1);
    step();
    wr_en = 1'b0;
    expect_val("read_x5_mux", K_RS1, 0, 32'hDEADBEEF, 0);
    step();

    // Write x0 is dropped; issue with rd=0 reserves nothing.
    idle_inputs();
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h12345678;
    issue_valid = 1'b1; issue_rd = 5'd0;
    expect_val("x0_no_bypass",  K_RS1,  0, 32'h0, 0);
    expect_val("x0_ready",      K_RDY,  0, 32'h1, 0);
    expect_val("x0_regs_flat",  K_REG,  0, 32'h0, 1);
    expect_val("rd0_busy",      K_BUSY, 0, 32'h0, 1);
    expect_val("rd0_cnt",       K_CNT,  0, 32'h0, 1);
    step();

    // Reserve x7, then a reader of x7 stalls until writeback releases it.
    idle_inputs();
    issue_valid = 1'b1; issue_rd = 5'd7;
    expect_val("rd7_ready",  K_RDY,  0, 32'h1,          0);
    expect_val("rd7_busy",   K_BUSY, 0, 32'h0000_0080,  1);
    expect_val("rd7_cnt",    K_CNT,  0, 32'h1,          1);
    step();
    issue_rd = 5'd0; rs2_addr = 5'd7;
    expect_val("raw_x7_stall", K_RDY, 0, 32'h0, 0);
    step();
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h55;
    expect_val("wb_x7_ready",   K_RDY,  0, 32'h1,  0);
    expect_val("wb_x7_bypass",  K_RS2,  0, 32'h55, 0);
    expect_val("wb_x7_release", K_BUSY, 0, 32'h0,  1);
    expect_val("wb_x7_cnt",     K_CNT,  0, 32'h0,  1);
    step();

    // Reserve x9, then same-cycle writeback and re-reservation of x9.
    idle_inputs();
    issue_valid = 1'b1; issue_rd = 5'd9;
    expect_val("rd9_busy", K_BUSY, 0, 32'h0000_0200, 1);
    step();
    expect_val("waw_x9_stall", K_RDY, 0, 32'h0, 0);
    step();
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hA5A5_0009;
    expect_val("wb_issue_x9_ready", K_RDY,  0, 32'h1,          0);
    expect_val("wb_issue_x9_busy",  K_BUSY, 0, 32'h0000_0200,  1);
    expect_val("wb_issue_x9_cnt",   K_CNT,  0, 32'h1,          1);
    expect_val("wb_issue_x9_reg",   K_REG,  9, 32'hA5A5_0009,  1);
    step();

    // Reserve x3, x4, x10 on top of x9.
    idle_inputs();
    issue_valid = 1'b1; issue_rd = 5'd3;
    step();
    issue_rd = 5'd4;
    step();
    issue_rd = 5'd10;
    expect_val("multi_busy", K_BUSY, 0, 32'h0000_0618, 1);
    expect_val("multi_cnt",  K_CNT,  0, 32'h4,         1);
    step();

    // Reset with a write and an issue in flight: all are discarded.
    rst = 1'b1;
    wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'hFFFF_FFFF;
    issue_valid = 1'b1; issue_rd = 5'd11;
    expect_val("rst_busy",  K_BUSY, 0,  32'h0, 1);
    expect_val("rst_cnt",   K_CNT,  0,  32'h0, 1);
    expect_val("rst_reg12", K_REG,  12, 32'h0, 1);
    expect_val("rst_reg5",  K_REG,  5,  32'h0, 1);
    expect_val("rst_reg9",  K_REG,  9,  32'h0, 1);
    step();
    rst = 1'b0;
    idle_inputs();
    rs1_addr = 5'd12; rs2_addr = 5'd5;
    expect_val("post_rst_rs1", K_RS1, 0, 32'h0, 0);
    expect_val("post_rst_rs2", K_RS2, 0, 32'h0, 0);
    expect_val("post_rst_rdy", K_RDY, 0, 32'h1, 0);
    step();

    // Write to a non-busy register: data lands, scoreboard untouched.
    wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'h0BAD_F00D;
    expect_val("nonbusy_wr_reg",  K_REG,  12, 32'h0BAD_F00D, 1);
    expect_val("nonbusy_wr_busy", K_BUSY, 0,  32'h0,         1);
    step();
    idle_inputs();

    checks++;
    if (regs_flat[12*XLEN +: XLEN] !== 32'h0BAD_F00D) begin
      errors++;
      $display("FAIL direct_reg12: got 0x%08h expected 0x0badf00d", regs_flat[12*XLEN +: XLEN]);
    end
    checks++;
    if (busy_flat !== '0) begin
      errors++;
      $display("FAIL direct_busy: got 0x%08h expected 0x00000000", busy_flat);
    end
    checks++;
    if (pending_cnt !== '0) begin
      errors++;
      $display("FAIL direct_cnt: got %0d expected 0", pending_cnt);
    end
    checks++;
    if (issue_ready !== 1'b1) begin
      errors++;
      $display("FAIL direct_ready: got %b expected 1", issue_ready);
    end
    rs1_addr = 5'd12;
    #1;
    checks++;
    if (rs1_data !== 32'h0BAD_F00D) begin
      errors++;
      $display("FAIL direct_rs1_x12: got 0x%08h expected 0x0badf00d", rs1_data);
    end

    step();
    step();

    done = 1'b1;
    while (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got no comparison expected one at cycle %0d", nq[0], q[0].cyc);
      q.delete(0);
      nq.delete(0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_regfile_scoreboard
